// File: rtl/pll_clken_supervisor.sv
// Purpose: supervises PLL lock, sequences the downstream reset and generates NCH aligned clock-enable trains.
// Latency: release SYNC_STAGES+LOCK_STABLE cycles after lock goes stable; every output is registered.
// Backpressure: none; div_ld and lost_clr are single-cycle strobes that are always accepted.
module pll_clken_supervisor #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_RST     = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CNT_W = $clog2(LOCK_STABLE)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             locked_in,
  input  logic             div_ld,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [DIV_W-1:0] div_val,
  input  logic             lost_clr,
  output logic [NCH-1:0]   clken,
  output logic             phase0,
  output logic             locked,
  output logic             rst_out_n,
  output logic             lost_lock
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  logic [CNT_W-1:0]       stab_q, stab_d;
  logic                   lost_q, lost_d;
  logic                   run_d;
  logic                   locked_q, rst_out_q;
  logic [DIV_W-1:0]       shd_q [NCH];
  logic [DIV_W-1:0]       shd_d [NCH];
  logic [DIV_W-1:0]       act_q [NCH];
  logic [DIV_W-1:0]       act_d [NCH];
  logic [DIV_W-1:0]       cnt_q [NCH];
  logic [DIV_W-1:0]       cnt_d [NCH];
  logic [NCH-1:0]         clken_q, clken_d;
  logic                   phase0_q, phase0_d;

  // Lock synchroniser: the only logic that sees the raw asynchronous lock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked_in};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock FSM: the stability counter's next value is what decides release, so RUN
  // is entered on the same edge the count reaches LOCK_STABLE-1.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          stab_d  = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + CNT_W'(1);
          if (stab_d == CNT_W'(LOCK_STABLE - 1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run_d = (state_d == RUN);

  // Sticky lost-lock flag: a loss in RUN beats a simultaneous clear.
  always_comb begin
    lost_d = lost_q;
    if ((state_q == RUN) && !locked_s) begin
      lost_d = 1'b1;
    end else if (lost_clr) begin
      lost_d = 1'b0;
    end
  end

  // Channel dividers: ratios only swap at terminal count (or outside RUN) so no
  // period is ever cut short or stretched; everything restarts at 0 on RUN entry.
  always_comb begin
    logic term;
    logic all_zero;
    term     = 1'b0;
    all_zero = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      shd_d[i] = shd_q[i];
      if (div_ld && (div_ch == CH_W'(i))) begin
        shd_d[i] = div_val;
      end
      term = (state_q == RUN) &&
             ((act_q[i] < DIV_W'(2)) || (cnt_q[i] == act_q[i] - DIV_W'(1)));
      act_d[i] = ((state_q != RUN) || term) ? shd_d[i] : act_q[i];
      if (run_d && (state_q == RUN) && !term) begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end else begin
        cnt_d[i] = '0;
      end
      clken_d[i] = run_d &&
                   ((act_d[i] < DIV_W'(2)) || (cnt_d[i] == act_d[i] - DIV_W'(1)));
      if (cnt_d[i] != '0) begin
        all_zero = 1'b0;
      end
    end
    phase0_d = run_d && all_zero;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= WAIT_LOCK;
      sync_q    <= '0;
      stab_q    <= '0;
      lost_q    <= 1'b0;
      locked_q  <= 1'b0;
      rst_out_q <= 1'b0;
      clken_q   <= '0;
      phase0_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shd_q[i] <= DIV_W'(DIV_RST);
        act_q[i] <= DIV_W'(DIV_RST);
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      stab_q    <= stab_d;
      lost_q    <= lost_d;
      locked_q  <= run_d;
      rst_out_q <= run_d;
      clken_q   <= clken_d;
      phase0_q  <= phase0_d;
      for (int i = 0; i < NCH; i++) begin
        shd_q[i] <= shd_d[i];
        act_q[i] <= act_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clken     = clken_q;
  assign phase0    = phase0_q;
  assign locked    = locked_q;
  assign rst_out_n = rst_out_q;
  assign lost_lock = lost_q;

endmodule

// File: tb/tb_pll_clken_supervisor.sv
// Bench for pll_clken_supervisor: directed lock/ratio scenarios checked every cycle
// against an event-style model (lock streak length, next-pulse schedule per channel)
// plus literal expectations at hand-computed cycles.
module tb_pll_clken_supervisor;

  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int DRST  = 2;
  localparam int LS    = 16;
  localparam int SYNC  = 2;

  logic             clk;
  logic             rst_n;
  logic             locked_in;
  logic             div_ld;
  logic [1:0]       div_ch;
  logic [DIV_W-1:0] div_val;
  logic             lost_clr;
  logic [NCH-1:0]   clken;
  logic             phase0;
  logic             locked;
  logic             rst_out_n;
  logic             lost_lock;

  int total = 0;
  int bad   = 0;

  pll_clken_supervisor #(
    .NCH(NCH), .DIV_W(DIV_W), .DIV_RST(DRST), .LOCK_STABLE(LS), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .locked_in(locked_in), .div_ld(div_ld),
    .div_ch(div_ch), .div_val(div_val), .lost_clr(lost_clr), .clken(clken),
    .phase0(phase0), .locked(locked), .rst_out_n(rst_out_n), .lost_lock(lost_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lock: RUN holds exactly while the synchronised lock has been high for the last
  // LS samples. Channels: each period starts at RUN entry or the cycle after a
  // pulse, takes the shadow ratio at that moment and pulses eff-1 cycles later.
  bit m_sync [SYNC];
  int m_streak;
  bit m_run;
  bit m_lost;
  int m_t;
  int m_shadow [NCH];
  int m_next [NCH];
  bit m_clk [NCH];
  bit m_ph;

  task automatic m_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = 1'b0;
    m_streak = 0;
    m_run    = 1'b0;
    m_lost   = 1'b0;
    m_t      = 0;
    m_ph     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = DRST;
      m_next[i]   = 0;
      m_clk[i]    = 1'b0;
    end
  endtask

  task automatic m_step();
    bit ls;
    bit was_run;
    bit all_start;
    int eff;
    m_t++;
    ls = m_sync[SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = locked_in;
    was_run   = m_run;
    m_streak  = ls ? m_streak + 1 : 0;
    m_run     = (m_streak >= LS);
    if (was_run && !ls) m_lost = 1'b1;
    else if (lost_clr)  m_lost = 1'b0;
    if (div_ld && (int'(div_ch) < NCH)) m_shadow[div_ch] = int'(div_val);
    all_start = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (!m_run) begin
        m_clk[i] = 1'b0;
      end else begin
        if (!was_run || m_clk[i]) begin
          eff       = (m_shadow[i] <= 1) ? 1 : m_shadow[i];
          m_next[i] = m_t + eff - 1;
        end else begin
          all_start = 1'b0;
        end
        m_clk[i] = (m_t == m_next[i]);
      end
    end
    m_ph = m_run && all_start;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [NCH+3:0] exp_v;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) exp_v[i+4] = m_clk[i];
      exp_v[3] = m_ph;
      exp_v[2] = m_run;
      exp_v[1] = m_run;
      exp_v[0] = m_lost;
      chk("model_cmp", 32'({clken, phase0, locked, rst_out_n, lost_lock}), 32'(exp_v));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int ch, input int val);
    div_ld  = 1'b1;
    div_ch  = 2'(ch);
    div_val = DIV_W'(val);
    cyc(1);
    div_ld  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int pcnt;
    rst_n = 1'b0; locked_in = 1'b0; div_ld = 1'b0; div_ch = '0;
    div_val = '0; lost_clr = 1'b0;
    cyc(2);
    chk("reset_outputs", 32'({clken, phase0, locked, rst_out_n, lost_lock}), 32'd0);

    // Release with lock already high: cycle 0 is this negedge.
    rst_n = 1'b1; locked_in = 1'b1;
    cyc(17);
    chk("c17_locked", 32'(locked), 32'd0);
    chk("c17_rst_out", 32'(rst_out_n), 32'd0);
    cyc(1);
    chk("c18_locked", 32'(locked), 32'd1);
    chk("c18_rst_out", 32'(rst_out_n), 32'd1);
    chk("c18_phase0", 32'(phase0), 32'd1);
    chk("c18_clken", 32'(clken), 32'h0);
    cyc(1);
    chk("c19_clken", 32'(clken), 32'hf);
    chk("c19_phase0", 32'(phase0), 32'd0);
    cyc(1);
    chk("c20_phase0", 32'(phase0), 32'd1);
    cyc(1);
    chk("c21_clken", 32'(clken), 32'hf);

    // Mid-run ratio loads; ch0 load coincides with its wrap, ch3 written twice.
    div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd5; cyc(1);
    div_ch = 2'd1; div_val = 8'd0; cyc(1);
    chk("c23_ch0_idle", 32'(clken[0]), 32'd0);
    div_ch = 2'd2; div_val = 8'd3; cyc(1);
    div_ch = 2'd3; div_val = 8'd7; cyc(1);
    chk("c25_ch0_idle", 32'(clken[0]), 32'd0);
    div_ch = 2'd3; div_val = 8'd4; cyc(1);
    chk("c26_ch0_new5", 32'(clken[0]), 32'd1);
    div_ld = 1'b0;
    cyc(12);
    for (int k = 0; k < 4; k++) begin
      chk("ch1_continuous", 32'(clken[1]), 32'd1);
      cyc(1);
    end

    // Pending ratios 2,3,4,1 applied once lock drops.
    load(0, 2); load(1, 3); load(2, 4); load(3, 1);
    cyc(3);
    locked_in = 1'b0;
    cyc(2);
    chk("drop_still_run", 32'(locked), 32'd1);
    cyc(1);
    chk("drop_locked", 32'(locked), 32'd0);
    chk("drop_rst_out", 32'(rst_out_n), 32'd0);
    chk("drop_clken", 32'(clken), 32'h0);
    chk("drop_lost", 32'(lost_lock), 32'd1);
    cyc(2);
    lost_clr = 1'b1; cyc(1); lost_clr = 1'b0;
    chk("lost_cleared", 32'(lost_lock), 32'd0);

    // Relock: RUN 18 cycles later, phase0 every lcm(2,3,4,1)=12 cycles.
    locked_in = 1'b1;
    cyc(17);
    chk("relock_c17", 32'(locked), 32'd0);
    cyc(1);
    chk("relock_c18", 32'(locked), 32'd1);
    chk("relock_phase0", 32'(phase0), 32'd1);
    pcnt = 1;
    for (int k = 0; k < 35; k++) begin
      cyc(1);
      if (phase0) pcnt++;
    end
    chk("phase0_lcm12", 32'(pcnt), 32'd3);

    // Lock loss and clear in the same cycle: set wins.
    locked_in = 1'b0;
    cyc(2);
    lost_clr = 1'b1; cyc(1); lost_clr = 1'b0;
    chk("set_beats_clr", 32'(lost_lock), 32'd1);
    lost_clr = 1'b1; cyc(1); lost_clr = 1'b0;
    chk("clr_after_set", 32'(lost_lock), 32'd0);

    // Short lock pulse never reaches RUN.
    locked_in = 1'b1; cyc(10); locked_in = 1'b0;
    cyc(30);
    chk("short_rst_out", 32'(rst_out_n), 32'd0);
    chk("short_lost", 32'(lost_lock), 32'd0);

    // Async reset mid-run.
    locked_in = 1'b1;
    cyc(18);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    cyc(5);
    chk("pre_rst_ch3", 32'(clken[3]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({clken, phase0, locked, rst_out_n, lost_lock}), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(18);
    chk("post_rst_locked", 32'(locked), 32'd1);
    cyc(1);
    chk("post_rst_div2", 32'(clken), 32'hf);
    cyc(1);
    chk("post_rst_gap", 32'(clken), 32'h0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
